uart_recv: RTL and testbench



---
 rtl/uart_recv_if.sv | 14 +
 rtl/uart_recv.sv | 100 ++++++++++
 tb/tb_uart_recv.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/uart_recv_if.sv
// Signal bundle between the UART receiver and its downstream consumer.
// master = receiver side (drives the received byte/status), slave = consumer side.
interface uart_recv_if;
  logic       uart_rxd;
  logic [7:0] uart_data;
  logic       uart_done;
  logic       frame_err;
  logic       rx_busy;

  modport master (input uart_rxd, output uart_data, output uart_done,
                  output frame_err, output rx_busy);
  modport slave  (output uart_rxd, input uart_data, input uart_done,
                  input frame_err, input rx_busy);
endinterface

// File: rtl/uart_recv.sv
// 8N1 UART receiver: synchronises RXD, samples each bit at mid-bit, strobes
// uart_done per good byte and frame_err when the stop bit is low.
//
// state | meaning
// IDLE  | waiting for a falling edge on the synchronised line
// START | timing the start bit; mid-bit high means a glitch
// DATA  | sampling 8 data bits, LSB first
// STOP  | sampling the stop bit; leaves at mid-bit to catch back-to-back frames
module uart_recv #(
  parameter int CLK_FREQ = 50000000,
  parameter int UART_BPS = 9600
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  uart_recv_if.master rx
);

  localparam int BPS_CNT  = CLK_FREQ / UART_BPS;
  localparam int HALF_CNT = BPS_CNT / 2;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state, next_state;
  logic        rxd_d0, rxd_d1, rxd_d2;
  logic [15:0] clk_cnt;
  logic [3:0]  bit_cnt;
  logic [7:0]  shift_reg;
  logic        start_edge, cnt_wrap, sample_pt;
  logic        done_set, err_set, shift_en;

  assign start_edge = rxd_d2 & ~rxd_d1;
  assign cnt_wrap   = (clk_cnt == 16'(BPS_CNT - 1));
  assign sample_pt  = (clk_cnt == 16'(HALF_CNT - 1));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= next_state;
  end

  always_comb begin
    next_state = state;
    done_set   = 1'b0;
    err_set    = 1'b0;
    shift_en   = 1'b0;
    case (state)
      IDLE:  if (start_edge) next_state = START;
      START: begin
        if (sample_pt && rxd_d1) next_state = IDLE;
        else if (cnt_wrap)       next_state = DATA;
      end
      DATA: begin
        shift_en = sample_pt;
        if (cnt_wrap && bit_cnt == 4'd7) next_state = STOP;
      end
      STOP: begin
        if (sample_pt) begin
          next_state = IDLE;
          done_set   = rxd_d1;
          err_set    = ~rxd_d1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rxd_d0       <= 1'b1;
      rxd_d1       <= 1'b1;
      rxd_d2       <= 1'b1;
      clk_cnt      <= '0;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      rx.uart_data <= '0;
      rx.uart_done <= 1'b0;
      rx.frame_err <= 1'b0;
      rx.rx_busy   <= 1'b0;
    end else begin
      rxd_d0 <= rx.uart_rxd;
      rxd_d1 <= rxd_d0;
      rxd_d2 <= rxd_d1;

      // Held at zero in IDLE so the first START cycle sees clk_cnt == 0.
      if (state == IDLE)  clk_cnt <= '0;
      else if (cnt_wrap)  clk_cnt <= '0;
      else                clk_cnt <= clk_cnt + 16'd1;

      if (state == IDLE)                   bit_cnt <= '0;
      else if (state == DATA && cnt_wrap)  bit_cnt <= bit_cnt + 4'd1;

      if (shift_en) shift_reg[bit_cnt[2:0]] <= rxd_d1;

      if (done_set) rx.uart_data <= shift_reg;
      rx.uart_done <= done_set;
      rx.frame_err <= err_set;
      rx.rx_busy   <= (next_state != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_recv.sv
// Directed + randomized bench for uart_recv at 16 clocks per bit; expected bytes,
// pulse counts and latencies come from a frame-level model of the UART protocol.
module tb_uart_recv;

  localparam int BPS  = 16;
  localparam int HALF = 8;
  // start_edge lags the pin by two synchroniser stages, done follows the stop sample by one
  localparam int LAT  = 9 * BPS + HALF + 1 + 2;

  logic sys_clk = 1'b0;
  logic sys_rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  uart_recv_if bus ();

  uart_recv #(.CLK_FREQ(160), .UART_BPS(10)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .rx        (bus)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int         done_cyc_q[$];
  logic [7:0] done_data_q[$];
  int         err_cyc_q[$];
  int         pulse_viol = 0;
  int         busy_viol = 0;
  logic       prev_done = 1'b0, prev_err = 1'b0, prev_busy = 1'b0;

  always @(negedge sys_clk) begin
    if (bus.uart_done === 1'b1) begin
      done_cyc_q.push_back(cyc);
      done_data_q.push_back(bus.uart_data);
      if (bus.rx_busy !== 1'b0 || prev_busy !== 1'b1) busy_viol <= busy_viol + 1;
    end
    if (bus.frame_err === 1'b1) err_cyc_q.push_back(cyc);
    if ((bus.uart_done && bus.frame_err) || (bus.uart_done && prev_done) ||
        (bus.frame_err && prev_err))
      pulse_viol <= pulse_viol + 1;
    prev_done <= bus.uart_done;
    prev_err  <= bus.frame_err;
    prev_busy <= bus.rx_busy;
  end

  logic [7:0] exp_data = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    bus.uart_rxd = v;
    repeat (BPS) @(negedge sys_clk);
  endtask

  task automatic idle_line(input int n);
    bus.uart_rxd = 1'b1;
    repeat (n) @(negedge sys_clk);
  endtask

  // One full frame; outcome checked against the protocol model.
  task automatic send_frame(input logic [7:0] b, input logic stop_ok);
    int nd, ne, sc;
    nd = done_cyc_q.size();
    ne = err_cyc_q.size();
    sc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_ok);
    #1;
    if (stop_ok) exp_data = b;
    chk("done_count", done_cyc_q.size(), nd + (stop_ok ? 1 : 0));
    chk("err_count", err_cyc_q.size(), ne + (stop_ok ? 0 : 1));
    if (stop_ok && done_cyc_q.size() > nd) begin
      chk("done_latency", done_cyc_q[nd] - sc, LAT);
      chk("done_byte", done_data_q[nd], b);
    end
    if (!stop_ok && err_cyc_q.size() > ne)
      chk("err_latency", err_cyc_q[ne] - sc, LAT);
    chk("uart_data", bus.uart_data, exp_data);
  endtask

  initial begin
    int nd, ne, busy_n, gap;
    logic [7:0] rb;
    logic       rs;

    sys_rst_n    = 1'b0;
    bus.uart_rxd = 1'b1;
    repeat (3) @(negedge sys_clk);
    chk("rst_data", bus.uart_data, 8'h00);
    chk("rst_done", bus.uart_done, 1'b0);
    chk("rst_err",  bus.frame_err, 1'b0);
    chk("rst_busy", bus.rx_busy,   1'b0);
    sys_rst_n = 1'b1;
    idle_line(10);

    send_frame(8'hA5, 1'b1);
    idle_line(10);

    nd = done_cyc_q.size();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    if (done_cyc_q.size() >= nd + 2)
      chk("b2b_spacing", done_cyc_q[nd+1] - done_cyc_q[nd], 10 * BPS);
    idle_line(10);

    nd = done_cyc_q.size();
    ne = err_cyc_q.size();
    busy_n = 0;
    bus.uart_rxd = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i == 4) bus.uart_rxd = 1'b1;
      @(negedge sys_clk);
      if (bus.rx_busy === 1'b1) busy_n++;
    end
    chk("glitch_busy_seen", busy_n > 0, 1'b1);
    chk("glitch_busy_le12", busy_n <= 12, 1'b1);
    chk("glitch_busy_end", bus.rx_busy, 1'b0);
    chk("glitch_no_done", done_cyc_q.size(), nd);
    chk("glitch_no_err", err_cyc_q.size(), ne);
    chk("glitch_data", bus.uart_data, exp_data);

    send_frame(8'h3C, 1'b0);
    nd = done_cyc_q.size();
    ne = err_cyc_q.size();
    bus.uart_rxd = 1'b0;
    repeat (3 * 10 * BPS) @(negedge sys_clk);
    #1;
    chk("break_no_done", done_cyc_q.size(), nd);
    chk("break_no_err", err_cyc_q.size(), ne);
    chk("break_data", bus.uart_data, 8'hFF);
    idle_line(20);
    send_frame(8'h5A, 1'b1);
    idle_line(10);

    nd = done_cyc_q.size();
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(rb_bit(8'h81, i));
    bus.uart_rxd = 1'b0;
    repeat (5) @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    exp_data = 8'h00;
    chk("midrst_data", bus.uart_data, 8'h00);
    chk("midrst_done", bus.uart_done, 1'b0);
    chk("midrst_err",  bus.frame_err, 1'b0);
    chk("midrst_busy", bus.rx_busy,   1'b0);
    bus.uart_rxd = 1'b1;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    idle_line(8);
    chk("midrst_no_done", done_cyc_q.size(), nd);
    send_frame(8'h42, 1'b1);

    for (int k = 0; k < 10; k++) begin
      rb  = 8'($urandom_range(0, 255));
      rs  = ($urandom_range(0, 3) != 0);
      // a low stop bit needs the line to rise again before the next start edge
      gap = int'($urandom_range(0, 20)) + (rs ? 0 : 2);
      send_frame(rb, rs);
      idle_line(gap);
    end
    idle_line(10);

    chk("pulse_rules", pulse_viol, 0);
    chk("busy_falls_with_done", busy_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  function automatic logic rb_bit(input logic [7:0] b, input int i);
    return b[i];
  endfunction

endmodule
